// File: rtl/clk_period_monitor.sv
// rtl/clk_period_monitor.sv - slow clock synchroniser with period, high-time, tolerance and loss checks
module clk_period_monitor #(
  parameter int SOURCE_CLOCK = 100000000,
  parameter int FREQ         = 100,
  parameter int TOL_CNT      = 1000,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_slow_clk,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_in_tol,
  output logic             o_lost
);

  localparam logic [CNT_W-1:0] EXP  = CNT_W'(SOURCE_CLOCK / FREQ);
  localparam logic [CNT_W-1:0] TO   = CNT_W'(2 * (SOURCE_CLOCK / FREQ));
  localparam logic [CNT_W-1:0] TOL  = CNT_W'(TOL_CNT);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_p;
  logic [1:0]       r_prime;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;

  logic             w_edge;
  logic             w_to;
  logic [CNT_W-1:0] w_diff;
  logic             w_in_tol;

  // A rise only counts once a real low level has come through the primed synchroniser,
  // so a clock already high at reset release produces no tick.
  assign w_edge   = r_s2 & ~r_p & r_armed;
  assign w_to     = (r_cnt == TO);
  assign w_diff   = (r_cnt >= EXP) ? (r_cnt - EXP) : (EXP - r_cnt);
  assign w_in_tol = (w_diff <= TOL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_p     <= 1'b0;
      r_prime <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= i_slow_clk;
      r_s2    <= r_s1;
      r_p     <= r_s2;
      r_prime <= {r_prime[0], 1'b1};
      r_armed <= r_armed | (r_prime[1] & ~r_s2);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_edge) begin
      r_cnt  <= CNT_W'(1);
      r_hcnt <= CNT_W'(1);
    end else begin
      if (r_cnt != CMAX) r_cnt <= r_cnt + CNT_W'(1);
      if (r_s2 && (r_hcnt != CMAX)) r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      o_tick   <= 1'b0;
      o_period <= '0;
      o_high   <= '0;
      o_valid  <= 1'b0;
      o_in_tol <= 1'b0;
      o_lost   <= 1'b0;
    end else begin
      o_tick  <= w_edge;
      o_valid <= 1'b0;
      case (r_state)
        IDLE, MEASURE: begin
          // An edge coinciding with the timeout is measured, never reported as loss.
          if (w_edge) begin
            r_state <= MEASURE;
            if (r_state == MEASURE) begin
              o_period <= r_cnt;
              o_high   <= r_hcnt;
              o_in_tol <= w_in_tol;
              o_valid  <= 1'b1;
            end
          end else if (w_to) begin
            r_state  <= LOST;
            o_lost   <= 1'b1;
            o_in_tol <= 1'b0;
          end
        end
        LOST: begin
          if (w_edge) begin
            r_state <= MEASURE;
            o_lost  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
